reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-dependence scoreboard for the five-stage pipeline, acting as the write-side tracker that pairs with the general register file. It records every issued instruction that will write a GPR and counts down until its result is forwardable and until it is committed to the register file. From that state it tells decode whether to stall, and tells each read port which forwarding source to use. It sits beside the decode stage, between the hazard controller and the forwarding muxes.

## Interface
- `WB_DELAY`, 3: cycles from issue edge until the register-file write edge; range 1–3.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clears all tracking state
- `issue_valid`  in  1  instruction leaving decode this cycle writes a GPR
- `issue_wa`  in  5  destination register of the issuing instruction
- `issue_tnew`  in  2  cycles after the issue edge until the result is forwardable; 0–3, clamped to `WB_DELAY`
- `rd_ra1`, `rd_ra2`  in  5 each  source registers of the instruction in decode
- `rd_tuse1`, `rd_tuse2`  in  2 each  cycles until decode needs each operand; 0 = needed now
- `stall`  out  1  decode must hold; asserted combinationally from current state
- `fwd_sel1`, `fwd_sel2`  out  2 each  0 = register file, 1 = E result, 2 = M result, 3 = W result

## Operation
- Per-register state, for r = 1..31:
  - `ready_cnt[r]` (2 b): cycles until the value is forwardable.
  - `wb_cnt[r]` (2 b): cycles until the register-file write.
  - r = 0 has no state and always reads as zero.
- Issue edge with `issue_valid` and `issue_wa != 0`:
  - `ready_cnt[wa] <= min(issue_tnew, WB_DELAY)`
  - `wb_cnt[wa] <= WB_DELAY`
- Every other register, every edge: each nonzero counter decrements by 1 and saturates at 0.
- Issue to $0 is ignored.
- Re-issue to a register already pending overwrites both counters. The newest writer wins; the older write still reaches the register file but is never selected.
- Per read port p:
  - `hazard_p = (ra_p != 0) && ready_cnt[ra_p] > tuse_p`
  - `stall = hazard_1 | hazard_2`
- Forward select from `wb_cnt[ra_p]` with k = `WB_DELAY`:
  - 0, or `ra_p == 0` → 0 (register file)
  - k → 1 (E)
  - k−1 → 2 (M)
  - k−2 → 3 (W)
  - Values are only meaningful when the corresponding stage exists for the chosen `WB_DELAY`.
- Reads always use pre-edge state. An instruction issuing in the same cycle does not affect the current cycle's `stall` or `fwd_sel`.
- `issue_valid` while `stall` is high is a protocol error. The block still applies the issue; the bench flags it with an assertion.
- The block has no flush input. Bubbles injected on stall need no action, because counters keep decrementing.

## Timing
- Reset: all counters are 0 at the edge following reset high, so `stall = 0` and `fwd_sel1 = fwd_sel2 = 0`.
- Reset overrides a simultaneous issue.
- `stall` and `fwd_sel*` are combinational from the counters and read inputs. There is no register stage on the outputs.
- With tnew = 1 and `WB_DELAY` = 3, a dependent instruction with tuse = 0:
  - stalls exactly 1 cycle;
  - then sees `fwd_sel = 2` (M);
  - next cycle 3 (W), then 0.
- Counter update is a single-cycle read-modify-write. Issue and decrement never both apply to the same register in one edge; issue wins.

## Structure
- Shared pipeline package holds:
  - the forward-select encodings (`FWD_GRF`, `FWD_E`, `FWD_M`, `FWD_W`);
  - the Tnew/Tuse width constant;
  - the `WB_DELAY` default.
- A natural sub-module, `sb_entry`, holds one register's two saturating down-counters, the issue-load input and the zero-flag outputs. It is instantiated 31 times; the top level contains only the read muxes and the compare logic.

## Test plan
- Reset then idle: `rd_ra1 = 5`, `tuse = 0` → `stall = 0`, `fwd_sel1 = 0`. Then issue to 5 with reset high → still 0 the next cycle.
- ALU chain: issue wa = 8, tnew = 1. Next cycle, read ra1 = 8, tuse = 0:
  - cycle 1: `stall = 1`
  - cycle 2: stall 0, fwd 2
  - cycle 3: fwd 3
  - cycle 4: fwd 0
- Load-use with slack: issue wa = 9, tnew = 2, then read ra2 = 9 with tuse = 1:
  - 1 stall cycle
  - then fwd_sel2 = 2, then 3, then 0
- $0 destination: issue wa = 0, tnew = 3, then read ra1 = 0, tuse = 0 → no stall, fwd 0 throughout.
- Overwrite: issue wa = 4, tnew = 0; next cycle issue wa = 4, tnew = 1. Next cycle read 4 with tuse = 0 → stall 1 cycle, then fwd sequence 2, 3, 0 tracks the second writer only.
- Dual operands: pending 3 (tnew = 2) and 7 (tnew = 1) issued on consecutive cycles; read ra1 = 3, ra2 = 7, tuse = 0 → stall until both clear; the final fwd_sel pair matches the computed ages.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register-dependence scoreboard:
// forward-select encodings, Tnew/Tuse width and write-back latency default.
package reg_scoreboard_pkg;

    localparam int T_W          = 2;
    localparam int WB_DELAY_DEF = 3;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    function automatic logic [T_W-1:0] clamp_tnew(input logic [T_W-1:0] tnew,
                                                   input logic [T_W-1:0] lim);
        return (tnew > lim) ? lim : tnew;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One tracked GPR: a readiness and a write-back saturating down-counter,
// reloaded on issue (issue takes priority over the decrement).
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int WB_DELAY = WB_DELAY_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_load,
    input  logic [T_W-1:0] i_tnew,
    output logic [T_W-1:0] o_ready_cnt,
    output logic [T_W-1:0] o_wb_cnt,
    output logic           o_ready_zero,
    output logic           o_wb_zero
);

    localparam logic [T_W-1:0] K = T_W'(WB_DELAY);

    logic [T_W-1:0] r_ready_cnt;
    logic [T_W-1:0] r_wb_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ready_cnt <= '0;
            r_wb_cnt    <= '0;
        end else if (i_load) begin
            r_ready_cnt <= clamp_tnew(i_tnew, K);
            r_wb_cnt    <= K;
        end else begin
            if (r_ready_cnt != '0) r_ready_cnt <= r_ready_cnt - 1'b1;
            if (r_wb_cnt != '0)    r_wb_cnt    <= r_wb_cnt - 1'b1;
        end
    end

    assign o_ready_cnt  = r_ready_cnt;
    assign o_wb_cnt     = r_wb_cnt;
    assign o_ready_zero = (r_ready_cnt == '0);
    assign o_wb_zero    = (r_wb_cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Write-side register scoreboard: per-GPR countdown entries, decode stall
// compare and per-read-port forwarding source selection.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int WB_DELAY = WB_DELAY_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_issue_valid,
    input  logic [4:0]     i_issue_wa,
    input  logic [T_W-1:0] i_issue_tnew,
    input  logic [4:0]     i_rd_ra1,
    input  logic [4:0]     i_rd_ra2,
    input  logic [T_W-1:0] i_rd_tuse1,
    input  logic [T_W-1:0] i_rd_tuse2,
    output logic           o_stall,
    output logic [1:0]     o_fwd_sel1,
    output logic [1:0]     o_fwd_sel2
);

    localparam logic [T_W-1:0] K = T_W'(WB_DELAY);

    logic [T_W-1:0] w_ready_cnt [32];
    logic [T_W-1:0] w_wb_cnt    [32];
    logic [31:0]    w_ready_zero;
    logic [31:0]    w_wb_zero;

    // $0 is never written, so its slot is tied to an idle entry.
    assign w_ready_cnt[0]  = '0;
    assign w_wb_cnt[0]     = '0;
    assign w_ready_zero[0] = 1'b1;
    assign w_wb_zero[0]    = 1'b1;

    for (genvar r = 1; r < 32; r++) begin : g_entry
        sb_entry #(.WB_DELAY(WB_DELAY)) u_entry (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_load       (i_issue_valid && (i_issue_wa == 5'(r))),
            .i_tnew       (i_issue_tnew),
            .o_ready_cnt  (w_ready_cnt[r]),
            .o_wb_cnt     (w_wb_cnt[r]),
            .o_ready_zero (w_ready_zero[r]),
            .o_wb_zero    (w_wb_zero[r])
        );
    end

    function automatic fwd_sel_e fwd_of(input logic [T_W-1:0] wb, input logic wb_zero);
        fwd_sel_e sel;
        sel = FWD_GRF;
        if (wb_zero)                  sel = FWD_GRF;
        else if (wb == K)             sel = FWD_E;
        else if (wb == K - 2'd1)      sel = FWD_M;
        else if (wb == K - 2'd2)      sel = FWD_W;
        return sel;
    endfunction

    logic w_hazard1;
    logic w_hazard2;

    always_comb begin
        w_hazard1  = !w_ready_zero[i_rd_ra1] && (w_ready_cnt[i_rd_ra1] > i_rd_tuse1);
        w_hazard2  = !w_ready_zero[i_rd_ra2] && (w_ready_cnt[i_rd_ra2] > i_rd_tuse2);
        o_stall    = w_hazard1 | w_hazard2;
        o_fwd_sel1 = fwd_of(w_wb_cnt[i_rd_ra1], w_wb_zero[i_rd_ra1]);
        o_fwd_sel2 = fwd_of(w_wb_cnt[i_rd_ra2], w_wb_zero[i_rd_ra2]);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with WB_DELAY = 3.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_wa;
    logic [1:0] issue_tnew;
    logic [4:0] rd_ra1, rd_ra2;
    logic [1:0] rd_tuse1, rd_tuse2;
    logic       stall;
    logic [1:0] fwd_sel1, fwd_sel2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.WB_DELAY(3)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_issue_valid (issue_valid),
        .i_issue_wa    (issue_wa),
        .i_issue_tnew  (issue_tnew),
        .i_rd_ra1      (rd_ra1),
        .i_rd_ra2      (rd_ra2),
        .i_rd_tuse1    (rd_tuse1),
        .i_rd_tuse2    (rd_tuse2),
        .o_stall       (stall),
        .o_fwd_sel1    (fwd_sel1),
        .o_fwd_sel2    (fwd_sel2)
    );

    // Issuing while decode is stalled is a protocol violation.
    always @(posedge clk) begin
        if (!reset && issue_valid)
            assert (!stall) else $error("protocol: issue while stall");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] wa, input logic [1:0] tnew);
        rd_ra1 = 5'd0; rd_ra2 = 5'd0;
        issue_valid = 1'b1; issue_wa = wa; issue_tnew = tnew;
        step();
        issue_valid = 1'b0; issue_wa = 5'd0; issue_tnew = 2'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; issue_valid = 1'b0; issue_wa = 5'd0; issue_tnew = 2'd0;
        rd_ra1 = 5'd0; rd_ra2 = 5'd0; rd_tuse1 = 2'd0; rd_tuse2 = 2'd0;
        step(); step();
        reset = 1'b0; rd_ra1 = 5'd5; rd_ra2 = 5'd5;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++;
        if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin
            n_errors++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_sel1, fwd_sel2);
        end
        rd_ra1 = 5'd0; rd_ra2 = 5'd0;
        reset = 1'b1; issue_valid = 1'b1; issue_wa = 5'd5; issue_tnew = 2'd3;
        step();
        reset = 1'b0; issue_valid = 1'b0; issue_wa = 5'd0; issue_tnew = 2'd0;
        rd_ra1 = 5'd5; rd_tuse1 = 2'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (stall !== 1'b0 || fwd_sel1 !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_over_issue[%0d]: got stall=%b fwd=%0d want 0/0", i, stall, fwd_sel1);
            end
            step();
        end
        rd_ra1 = 5'd0;
    endtask

    task automatic test_alu_chain();
        logic       es [4];
        logic [1:0] ef [4];
        es = '{1'b1, 1'b0, 1'b0, 1'b0};
        ef = '{2'd1, 2'd2, 2'd3, 2'd0};
        issue(5'd8, 2'd1);
        rd_ra1 = 5'd8; rd_tuse1 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== es[i] || fwd_sel1 !== ef[i]) begin
                n_errors++;
                $display("FAIL alu_chain[%0d]: got stall=%b fwd1=%0d want %b/%0d", i, stall, fwd_sel1, es[i], ef[i]);
            end
            step();
        end
        rd_ra1 = 5'd0;
    endtask

    task automatic test_load_use();
        logic       es [4];
        logic [1:0] ef [4];
        es = '{1'b1, 1'b0, 1'b0, 1'b0};
        ef = '{2'd1, 2'd2, 2'd3, 2'd0};
        issue(5'd9, 2'd2);
        rd_ra2 = 5'd9; rd_tuse2 = 2'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== es[i] || fwd_sel2 !== ef[i]) begin
                n_errors++;
                $display("FAIL load_use[%0d]: got stall=%b fwd2=%0d want %b/%0d", i, stall, fwd_sel2, es[i], ef[i]);
            end
            step();
        end
        rd_ra2 = 5'd0; rd_tuse2 = 2'd0;
    endtask

    task automatic test_zero_dest();
        issue(5'd0, 2'd3);
        rd_ra1 = 5'd0; rd_tuse1 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== 1'b0 || fwd_sel1 !== 2'd0) begin
                n_errors++;
                $display("FAIL zero_dest[%0d]: got stall=%b fwd1=%0d want 0/0", i, stall, fwd_sel1);
            end
            step();
        end
    endtask

    task automatic test_overwrite();
        logic       es [4];
        logic [1:0] ef [4];
        es = '{1'b1, 1'b0, 1'b0, 1'b0};
        ef = '{2'd1, 2'd2, 2'd3, 2'd0};
        issue(5'd4, 2'd0);
        issue(5'd4, 2'd1);
        rd_ra1 = 5'd4; rd_tuse1 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== es[i] || fwd_sel1 !== ef[i]) begin
                n_errors++;
                $display("FAIL overwrite[%0d]: got stall=%b fwd1=%0d want %b/%0d", i, stall, fwd_sel1, es[i], ef[i]);
            end
            step();
        end
        rd_ra1 = 5'd0;
    endtask

    task automatic test_dual();
        logic       es  [4];
        logic [1:0] ef1 [4];
        logic [1:0] ef2 [4];
        es  = '{1'b1, 1'b0, 1'b0, 1'b0};
        ef1 = '{2'd2, 2'd3, 2'd0, 2'd0};
        ef2 = '{2'd1, 2'd2, 2'd3, 2'd0};
        issue(5'd3, 2'd2);
        issue(5'd7, 2'd1);
        rd_ra1 = 5'd3; rd_ra2 = 5'd7; rd_tuse1 = 2'd0; rd_tuse2 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== es[i] || fwd_sel1 !== ef1[i] || fwd_sel2 !== ef2[i]) begin
                n_errors++;
                $display("FAIL dual[%0d]: got stall=%b fwd=%0d/%0d want %b/%0d/%0d",
                         i, stall, fwd_sel1, fwd_sel2, es[i], ef1[i], ef2[i]);
            end
            step();
        end
        rd_ra1 = 5'd0; rd_ra2 = 5'd0;
    endtask

    // tnew = 3 against tuse = 2 and tuse = 3: stall only when ready exceeds tuse.
    task automatic test_tuse_boundary();
        logic       es [4];
        es = '{1'b1, 1'b0, 1'b0, 1'b0};
        issue(5'd10, 2'd3);
        rd_ra1 = 5'd10; rd_tuse1 = 2'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (stall !== es[i]) begin
                n_errors++;
                $display("FAIL tuse_boundary[%0d]: got stall=%b want %b", i, stall, es[i]);
            end
            step();
        end
        issue(5'd11, 2'd3);
        rd_ra1 = 5'd11; rd_tuse1 = 2'd3;
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd1) begin
            n_errors++;
            $display("FAIL tuse_equal: got stall=%b fwd1=%0d want 0/1", stall, fwd_sel1);
        end
        step(); step(); step();
        rd_ra1 = 5'd0; rd_tuse1 = 2'd0;
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_zero_dest();
        test_overwrite();
        test_dual();
        test_tuse_boundary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
